// File: rtl/e203_ifu_flush_rsp_pkg.sv
// Shared sizes, FSM encoding and counter helper for the IFU flush/response tracker.
// The E203_FLUSH_PC_DIRECT_EN option is resolved in the top module, not here.
package e203_ifu_flush_rsp_pkg;

  localparam int E203_PC_SIZE      = 32;
  localparam int E203_IFU_OUTS_NUM = 2;
  localparam int OUTS_W            = $clog2(E203_IFU_OUTS_NUM + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DRAIN   = 2'b01,
    ST_REFETCH = 2'b10
  } flush_state_e;

  // cnt + inc - dec, clamped to [0, E203_IFU_OUTS_NUM]
  function automatic logic [OUTS_W-1:0] outs_step(input logic [OUTS_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
    logic [OUTS_W:0] sum;
    sum = {1'b0, cnt} + {{OUTS_W{1'b0}}, inc};
    if (dec) begin
      sum = (sum == '0) ? '0 : sum - (OUTS_W+1)'(1);
    end
    if (sum > (OUTS_W+1)'(E203_IFU_OUTS_NUM)) begin
      sum = (OUTS_W+1)'(E203_IFU_OUTS_NUM);
    end
    return sum[OUTS_W-1:0];
  endfunction

endpackage

// File: rtl/e203_ifu_flush_rsp.sv
// IFU flush handling: drains fetches outstanding at flush time, then redirects to new_pc.
// Define E203_FLUSH_PC_DIRECT_EN to take the target from pipe_flush_pc instead of op1+op2.
module e203_ifu_flush_rsp
  import e203_ifu_flush_rsp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pipe_flush_req,
  input  logic [E203_PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [E203_PC_SIZE-1:0] pipe_flush_add_op2,
`ifdef E203_FLUSH_PC_DIRECT_EN
  input  logic [E203_PC_SIZE-1:0] pipe_flush_pc,
`endif
  output logic                    pipe_flush_ack,
  input  logic                    ifu_req_hsked,
  input  logic                    ifu_rsp_hsked,
  output logic                    rsp_discard,
  output logic                    fetch_halt,
  output logic                    new_pc_vld,
  output logic [E203_PC_SIZE-1:0] new_pc
);

  flush_state_e              r_state;
  flush_state_e              w_state_next;
  logic [OUTS_W-1:0]         r_outs;
  logic [OUTS_W-1:0]         r_drain_cnt;
  logic [OUTS_W-1:0]         w_drain_next;
  logic [OUTS_W-1:0]         w_drain_init;
  logic [OUTS_W-1:0]         w_outs_next;
  logic [E203_PC_SIZE-1:0]   r_new_pc;
  logic [E203_PC_SIZE-1:0]   w_flush_target;
  logic                      w_accept;
  logic                      w_in_drain;

`ifdef E203_FLUSH_PC_DIRECT_EN
  assign w_flush_target = pipe_flush_pc;
`else
  assign w_flush_target = pipe_flush_add_op1 + pipe_flush_add_op2;
`endif

  assign w_in_drain   = (r_state == ST_DRAIN);
  assign w_accept     = pipe_flush_req & (r_state == ST_IDLE);
  // Requests seen while draining break the ICB protocol and are not counted.
  assign w_outs_next  = outs_step(r_outs, ifu_req_hsked & ~w_in_drain, ifu_rsp_hsked);
  assign w_drain_init = outs_step(r_outs, ifu_req_hsked, ifu_rsp_hsked);

  always_comb begin
    w_state_next   = r_state;
    w_drain_next   = r_drain_cnt;
    pipe_flush_ack = 1'b0;
    rsp_discard    = 1'b0;
    fetch_halt     = 1'b0;
    new_pc_vld     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        pipe_flush_ack = 1'b1;
        if (w_accept) begin
          rsp_discard  = ifu_rsp_hsked;
          w_drain_next = w_drain_init;
          w_state_next = (w_drain_init != '0) ? ST_DRAIN : ST_REFETCH;
        end
      end
      ST_DRAIN: begin
        rsp_discard = 1'b1;
        fetch_halt  = 1'b1;
        if (r_drain_cnt == '0) begin
          w_state_next = ST_REFETCH;
        end else if (ifu_rsp_hsked) begin
          w_drain_next = r_drain_cnt - OUTS_W'(1);
          if (r_drain_cnt == OUTS_W'(1)) begin
            w_state_next = ST_REFETCH;
          end
        end
      end
      ST_REFETCH: begin
        fetch_halt = 1'b1;
        new_pc_vld = 1'b1;
        if (ifu_req_hsked) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_drain_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_outs      <= '0;
      r_drain_cnt <= '0;
      r_new_pc    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_outs      <= w_outs_next;
      r_drain_cnt <= w_drain_next;
      if (w_accept) begin
        r_new_pc <= w_flush_target;
      end
    end
  end

  assign new_pc = r_new_pc;

endmodule
